// File: rtl/cascade_mod_counter_if.sv
// rtl/cascade_mod_counter_if.sv - control and status bundle for one counter stage
// The master side drives stepping and load controls, and the slave side returns count and carry status.
interface cascade_mod_counter_if #(
  parameter int WIDTH = 6
);
  logic             en;
  logic             carry_in;
  logic             up_down;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] mod_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             carry_out;
  logic             wrapped;

  modport master (
    output en, carry_in, up_down, load, load_val, mod_val,
    input  count, tc, carry_out, wrapped
  );

  modport slave (
    input  en, carry_in, up_down, load, load_val, mod_val,
    output count, tc, carry_out, wrapped
  );
endinterface

// File: rtl/cascade_mod_counter.sv
// rtl/cascade_mod_counter.sv - cascadable up/down modulo counter with load and wrap/saturate
// Stages chain carry_out to carry_in, so a wrap ripples to the next stage on the same edge.
module cascade_mod_counter #(
  parameter int WIDTH    = 6,
  parameter int SATURATE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  cascade_mod_counter_if.slave  bus
);
  localparam logic             WRAP = (SATURATE == 0);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] max_val;
  logic             wrapped_q;
  logic             wrapped_d;
  logic             step;
  logic             tc;

  // mod_val==0 selects the full 2^WIDTH range without widening the arithmetic
  assign max_val = (bus.mod_val == '0) ? {WIDTH{1'b1}} : bus.mod_val - ONE;
  assign step    = bus.en & bus.carry_in;
  assign tc      = bus.up_down ? (count_q == '0) : (count_q >= max_val);

  always_comb begin
    count_d   = count_q;
    wrapped_d = 1'b0;
    if (bus.load) begin
      count_d = (bus.load_val > max_val) ? max_val : bus.load_val;
    end else if (step) begin
      if (!bus.up_down) begin
        if (count_q < max_val) begin
          count_d = count_q + ONE;
        end else if (WRAP) begin
          count_d   = '0;
          wrapped_d = 1'b1;
        end
      end else begin
        // after a modulus shrink, a down step first pulls the count back into range
        if (count_q > max_val) begin
          count_d = max_val;
        end else if (count_q != '0) begin
          count_d = count_q - ONE;
        end else if (WRAP) begin
          count_d   = max_val;
          wrapped_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q   <= '0;
      wrapped_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign bus.count     = count_q;
  assign bus.wrapped   = wrapped_q;
  assign bus.tc        = tc;
  assign bus.carry_out = step & tc & ~bus.load & WRAP;
endmodule

// File: tb/tb_cascade_mod_counter.sv
// tb/tb_cascade_mod_counter.sv - directed and randomized checks of cascade_mod_counter
// Inputs change on the falling edge and outputs are sampled 1ns later, away from the active edge.
module tb_cascade_mod_counter;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  cascade_mod_counter_if #(.WIDTH(6)) ifa ();
  cascade_mod_counter_if #(.WIDTH(6)) ifb ();
  cascade_mod_counter_if #(.WIDTH(6)) ifs ();
  cascade_mod_counter_if #(.WIDTH(4)) if4 ();

  assign ifb.carry_in = ifa.carry_out;

  cascade_mod_counter #(.WIDTH(6), .SATURATE(0)) dut_lo  (.clk(clk), .rst(rst), .bus(ifa));
  cascade_mod_counter #(.WIDTH(6), .SATURATE(0)) dut_hi  (.clk(clk), .rst(rst), .bus(ifb));
  cascade_mod_counter #(.WIDTH(6), .SATURATE(1)) dut_sat (.clk(clk), .rst(rst), .bus(ifs));
  cascade_mod_counter #(.WIDTH(4), .SATURATE(0)) dut_w4  (.clk(clk), .rst(rst), .bus(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit r_en [3];
  bit r_cin[3];
  bit r_dn [3];
  bit r_ld [3];
  int r_lv [3];
  int r_mv [3];
  int m_cnt[3];
  bit m_wr [3];

  function automatic int ref_max(input int w, input int mv);
    return (mv == 0) ? (1 << w) - 1 : mv - 1;
  endfunction

  function automatic void ref_next(input int w, input bit s, input int cnt, input bit rs,
                                   input bit ld, input bit en, input bit cin, input bit dn,
                                   input int lv, input int mv, output int ncnt, output bit nwr);
    int m;
    m    = ref_max(w, mv) + 1;
    ncnt = cnt;
    nwr  = 1'b0;
    if (!rs) ncnt = 0;
    else if (ld) ncnt = (lv >= m) ? m - 1 : lv;
    else if (en && cin) begin
      if (!dn) begin
        if (cnt + 1 < m) ncnt = cnt + 1;
        else if (!s) begin ncnt = 0; nwr = 1'b1; end
      end else begin
        if (cnt >= m) ncnt = m - 1;
        else if (cnt > 0) ncnt = cnt - 1;
        else if (!s) begin ncnt = m - 1; nwr = 1'b1; end
      end
    end
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    ifa.load = 1'b1; ifa.load_val = 6'd7; ifa.en = 1'b1; ifa.carry_in = 1'b1;
    @(negedge clk); #1;
    total++; if (ifa.count !== 6'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", ifa.count); end
    total++; if (ifa.wrapped !== 1'b0) begin bad++; $display("FAIL reset_wrapped got=%b exp=0", ifa.wrapped); end
    total++; if (ifs.count !== 6'd0) begin bad++; $display("FAIL reset_sat_count got=%0d exp=0", ifs.count); end
    total++; if (if4.count !== 4'd0) begin bad++; $display("FAIL reset_w4_count got=%0d exp=0", if4.count); end
    total++; if (ifa.carry_out !== 1'b0) begin bad++; $display("FAIL reset_co_load got=%b exp=0", ifa.carry_out); end
    ifa.load = 1'b0; ifa.en = 1'b0; #1;
    total++; if (ifa.tc !== 1'b0) begin bad++; $display("FAIL reset_tc got=%b exp=0", ifa.tc); end
  endtask

  task automatic test_wrap_up();
    @(negedge clk);
    rst = 1'b1;
    ifa.mod_val = 6'd60; ifa.up_down = 1'b0; ifa.load = 1'b0; ifa.en = 1'b1; ifa.carry_in = 1'b1;
    for (int i = 0; i <= 60; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      total++; if (int'(ifa.count) !== i % 60) begin bad++; $display("FAIL up_count i=%0d got=%0d exp=%0d", i, ifa.count, i % 60); end
      total++; if (ifa.carry_out !== (i == 59)) begin bad++; $display("FAIL up_co i=%0d got=%b exp=%b", i, ifa.carry_out, i == 59); end
      total++; if (ifa.tc !== (i == 59)) begin bad++; $display("FAIL up_tc i=%0d got=%b exp=%b", i, ifa.tc, i == 59); end
      total++; if (ifa.wrapped !== (i == 60)) begin bad++; $display("FAIL up_wrapped i=%0d got=%b exp=%b", i, ifa.wrapped, i == 60); end
    end
  endtask

  task automatic test_down();
    int seq[8];
    seq = '{5, 4, 3, 2, 1, 0, 59, 58};
    @(negedge clk);
    ifa.load = 1'b1; ifa.load_val = 6'd5; ifa.up_down = 1'b1;
    #1;
    total++; if (ifa.carry_out !== 1'b0) begin bad++; $display("FAIL down_load_co got=%b exp=0", ifa.carry_out); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ifa.load = 1'b0;
      #1;
      total++; if (int'(ifa.count) !== seq[k]) begin bad++; $display("FAIL down_count k=%0d got=%0d exp=%0d", k, ifa.count, seq[k]); end
      total++; if (ifa.tc !== (seq[k] == 0)) begin bad++; $display("FAIL down_tc k=%0d got=%b exp=%b", k, ifa.tc, seq[k] == 0); end
      total++; if (ifa.carry_out !== (seq[k] == 0)) begin bad++; $display("FAIL down_co k=%0d got=%b exp=%b", k, ifa.carry_out, seq[k] == 0); end
      total++; if (ifa.wrapped !== (k == 6)) begin bad++; $display("FAIL down_wrapped k=%0d got=%b exp=%b", k, ifa.wrapped, k == 6); end
    end
  endtask

  task automatic test_chain();
    @(negedge clk);
    ifa.load = 1'b1; ifa.load_val = 6'd59; ifa.mod_val = 6'd60; ifa.up_down = 1'b0; ifa.en = 1'b1; ifa.carry_in = 1'b1;
    ifb.load = 1'b1; ifb.load_val = 6'd59; ifb.mod_val = 6'd60; ifb.up_down = 1'b0; ifb.en = 1'b1;
    @(negedge clk);
    ifa.load = 1'b0; ifb.load = 1'b0;
    #1;
    total++; if (ifa.count !== 6'd59) begin bad++; $display("FAIL chain_lo_pre got=%0d exp=59", ifa.count); end
    total++; if (ifb.count !== 6'd59) begin bad++; $display("FAIL chain_hi_pre got=%0d exp=59", ifb.count); end
    total++; if (ifb.carry_out !== 1'b1) begin bad++; $display("FAIL chain_hi_co got=%b exp=1", ifb.carry_out); end
    @(negedge clk);
    ifa.en = 1'b0; ifb.en = 1'b0;
    #1;
    total++; if (ifa.count !== 6'd0) begin bad++; $display("FAIL chain_lo_post got=%0d exp=0", ifa.count); end
    total++; if (ifb.count !== 6'd0) begin bad++; $display("FAIL chain_hi_post got=%0d exp=0", ifb.count); end
    total++; if (ifb.wrapped !== 1'b1) begin bad++; $display("FAIL chain_hi_wrapped got=%b exp=1", ifb.wrapped); end
  endtask

  task automatic test_saturate();
    @(negedge clk);
    ifs.mod_val = 6'd24; ifs.load = 1'b1; ifs.load_val = 6'd23; ifs.up_down = 1'b0; ifs.en = 1'b1; ifs.carry_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ifs.load = 1'b0;
      #1;
      total++; if (ifs.count !== 6'd23) begin bad++; $display("FAIL sat_count k=%0d got=%0d exp=23", k, ifs.count); end
      total++; if (ifs.tc !== 1'b1) begin bad++; $display("FAIL sat_tc k=%0d got=%b exp=1", k, ifs.tc); end
      total++; if (ifs.carry_out !== 1'b0) begin bad++; $display("FAIL sat_co k=%0d got=%b exp=0", k, ifs.carry_out); end
      total++; if (ifs.wrapped !== 1'b0) begin bad++; $display("FAIL sat_wrapped k=%0d got=%b exp=0", k, ifs.wrapped); end
    end
    ifs.up_down = 1'b1;
    #1;
    total++; if (ifs.tc !== 1'b0) begin bad++; $display("FAIL sat_dir_tc got=%b exp=0", ifs.tc); end
    @(negedge clk);
    ifs.en = 1'b0;
    #1;
    total++; if (ifs.count !== 6'd22) begin bad++; $display("FAIL sat_down got=%0d exp=22", ifs.count); end
  endtask

  task automatic test_modchange();
    @(negedge clk);
    ifa.load = 1'b1; ifa.load_val = 6'd50; ifa.mod_val = 6'd24; ifa.en = 1'b0; ifa.up_down = 1'b0;
    @(negedge clk);
    ifa.load = 1'b0;
    #1;
    total++; if (ifa.count !== 6'd23) begin bad++; $display("FAIL mod_clamp got=%0d exp=23", ifa.count); end
    ifa.mod_val = 6'd10;
    #1;
    total++; if (ifa.tc !== 1'b1) begin bad++; $display("FAIL mod_tc got=%b exp=1", ifa.tc); end
    ifa.en = 1'b1; ifa.carry_in = 1'b1;
    #1;
    total++; if (ifa.carry_out !== 1'b1) begin bad++; $display("FAIL mod_co got=%b exp=1", ifa.carry_out); end
    @(negedge clk);
    ifa.en = 1'b0;
    #1;
    total++; if (ifa.count !== 6'd0) begin bad++; $display("FAIL mod_wrap got=%0d exp=0", ifa.count); end
    total++; if (ifa.wrapped !== 1'b1) begin bad++; $display("FAIL mod_wrapped got=%b exp=1", ifa.wrapped); end
  endtask

  task automatic test_priority();
    @(negedge clk);
    ifa.mod_val = 6'd60; ifa.up_down = 1'b1; ifa.load = 1'b1; ifa.load_val = 6'd33; ifa.en = 1'b1; ifa.carry_in = 1'b1;
    #1;
    total++; if (ifa.tc !== 1'b1) begin bad++; $display("FAIL prio_tc got=%b exp=1", ifa.tc); end
    total++; if (ifa.carry_out !== 1'b0) begin bad++; $display("FAIL prio_load_co got=%b exp=0", ifa.carry_out); end
    @(negedge clk);
    ifa.load = 1'b0; ifa.en = 1'b0;
    #1;
    total++; if (ifa.count !== 6'd33) begin bad++; $display("FAIL prio_load_count got=%0d exp=33", ifa.count); end
    total++; if (ifa.wrapped !== 1'b0) begin bad++; $display("FAIL prio_load_wrapped got=%b exp=0", ifa.wrapped); end

    @(negedge clk);
    if4.mod_val = 4'd0; if4.load = 1'b1; if4.load_val = 4'd15; if4.up_down = 1'b0; if4.en = 1'b0; if4.carry_in = 1'b1;
    @(negedge clk);
    if4.load = 1'b0; if4.en = 1'b1;
    #1;
    total++; if (if4.count !== 4'd15) begin bad++; $display("FAIL full_count got=%0d exp=15", if4.count); end
    total++; if (if4.carry_out !== 1'b1) begin bad++; $display("FAIL full_co got=%b exp=1", if4.carry_out); end
    @(negedge clk);
    if4.en = 1'b0;
    #1;
    total++; if (if4.count !== 4'd0) begin bad++; $display("FAIL full_wrap got=%0d exp=0", if4.count); end
    total++; if (if4.wrapped !== 1'b1) begin bad++; $display("FAIL full_wrapped got=%b exp=1", if4.wrapped); end

    @(negedge clk);
    if4.mod_val = 4'd1; if4.load = 1'b1; if4.load_val = 4'd9;
    @(negedge clk);
    if4.load = 1'b0;
    #1;
    total++; if (if4.count !== 4'd0) begin bad++; $display("FAIL mod1_count got=%0d exp=0", if4.count); end
    total++; if (if4.tc !== 1'b1) begin bad++; $display("FAIL mod1_tc got=%b exp=1", if4.tc); end
    if4.en = 1'b1;
    #1;
    total++; if (if4.carry_out !== 1'b1) begin bad++; $display("FAIL mod1_co got=%b exp=1", if4.carry_out); end
    @(negedge clk);
    if4.en = 1'b0;
    #1;
    total++; if (if4.wrapped !== 1'b1) begin bad++; $display("FAIL mod1_wrapped got=%b exp=1", if4.wrapped); end
  endtask

  task automatic apply_rand();
    ifa.en = r_en[0]; ifa.carry_in = r_cin[0]; ifa.up_down = r_dn[0]; ifa.load = r_ld[0];
    ifa.load_val = 6'(r_lv[0]); ifa.mod_val = 6'(r_mv[0]);
    ifs.en = r_en[1]; ifs.carry_in = r_cin[1]; ifs.up_down = r_dn[1]; ifs.load = r_ld[1];
    ifs.load_val = 6'(r_lv[1]); ifs.mod_val = 6'(r_mv[1]);
    if4.en = r_en[2]; if4.carry_in = r_cin[2]; if4.up_down = r_dn[2]; if4.load = r_ld[2];
    if4.load_val = 4'(r_lv[2]); if4.mod_val = 4'(r_mv[2]);
  endtask

  task automatic test_random();
    int   wd[3];
    bit   sat[3];
    int   a_cnt;
    logic a_tc, a_co, a_wr;
    bit   e_tc, e_co;
    int   mx, ncnt;
    bit   nwr;
    wd  = '{6, 6, 4};
    sat = '{1'b0, 1'b1, 1'b0};
    r_mv = '{60, 24, 12};
    for (int d = 0; d < 3; d++) begin
      r_en[d] = 1'b0; r_cin[d] = 1'b0; r_dn[d] = 1'b0; r_ld[d] = 1'b0; r_lv[d] = 0;
    end
    ifb.en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    apply_rand();
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin m_cnt[d] = 0; m_wr[d] = 1'b0; end
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) != 0);
      for (int d = 0; d < 3; d++) begin
        r_en[d]  = ($urandom_range(0, 3) != 0);
        r_cin[d] = ($urandom_range(0, 3) != 0);
        r_dn[d]  = 1'($urandom_range(0, 1));
        r_ld[d]  = ($urandom_range(0, 7) == 0);
        r_lv[d]  = int'($urandom_range(0, (1 << wd[d]) - 1));
        if ($urandom_range(0, 15) == 0) r_mv[d] = int'($urandom_range(0, (1 << wd[d]) - 1));
      end
      apply_rand();
      #1;
      for (int d = 0; d < 3; d++) begin
        case (d)
          0:       begin a_cnt = int'(ifa.count); a_tc = ifa.tc; a_co = ifa.carry_out; a_wr = ifa.wrapped; end
          1:       begin a_cnt = int'(ifs.count); a_tc = ifs.tc; a_co = ifs.carry_out; a_wr = ifs.wrapped; end
          default: begin a_cnt = int'(if4.count); a_tc = if4.tc; a_co = if4.carry_out; a_wr = if4.wrapped; end
        endcase
        mx   = ref_max(wd[d], r_mv[d]);
        e_tc = r_dn[d] ? (m_cnt[d] == 0) : (m_cnt[d] >= mx);
        e_co = r_en[d] && r_cin[d] && e_tc && !r_ld[d] && !sat[d];
        total++; if (a_cnt !== m_cnt[d]) begin bad++; $display("FAIL rand_count d=%0d c=%0d got=%0d exp=%0d", d, c, a_cnt, m_cnt[d]); end
        total++; if (a_tc !== e_tc) begin bad++; $display("FAIL rand_tc d=%0d c=%0d got=%b exp=%b", d, c, a_tc, e_tc); end
        total++; if (a_co !== e_co) begin bad++; $display("FAIL rand_co d=%0d c=%0d got=%b exp=%b", d, c, a_co, e_co); end
        total++; if (a_wr !== m_wr[d]) begin bad++; $display("FAIL rand_wrapped d=%0d c=%0d got=%b exp=%b", d, c, a_wr, m_wr[d]); end
        ref_next(wd[d], sat[d], m_cnt[d], rst, r_ld[d], r_en[d], r_cin[d], r_dn[d], r_lv[d], r_mv[d], ncnt, nwr);
        m_cnt[d] = ncnt;
        m_wr[d]  = nwr;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    ifa.en = 1'b0; ifa.carry_in = 1'b1; ifa.up_down = 1'b0; ifa.load = 1'b0; ifa.load_val = '0; ifa.mod_val = 6'd60;
    ifb.en = 1'b0; ifb.up_down = 1'b0; ifb.load = 1'b0; ifb.load_val = '0; ifb.mod_val = 6'd60;
    ifs.en = 1'b0; ifs.carry_in = 1'b1; ifs.up_down = 1'b0; ifs.load = 1'b0; ifs.load_val = '0; ifs.mod_val = 6'd24;
    if4.en = 1'b0; if4.carry_in = 1'b1; if4.up_down = 1'b0; if4.load = 1'b0; if4.load_val = '0; if4.mod_val = 4'd0;
    test_reset();
    test_wrap_up();
    test_down();
    test_chain();
    test_saturate();
    test_modchange();
    test_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
